// File: rtl/mem_frame_loader_pkg.sv
// mem_frame_loader_pkg: shared constants and state encoding for the frame loader
// and the register memory it feeds.
package mem_frame_loader_pkg;

   localparam int         MEM_DEPTH = 102;
   localparam logic [7:0] DEPTH_B   = 8'(MEM_DEPTH);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_CHK,
      S_DONE
   } state_t;

endpackage

// File: rtl/mem_frame_loader_if.sv
// mem_frame_loader_if: byte-stream input handshake plus memory write port.
//   in_data/in_valid  : stream byte from the serial front-end
//   in_ready          : loader accepts a byte this cycle
//   mem_addr/mem_data : registered write address/data to the memory
//   mem_we            : registered write strobe, one cycle per byte
//   slave modport     : the loader side; master modport: the environment side
interface mem_frame_loader_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_we;

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_addr, mem_data, mem_we
   );

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_addr, mem_data, mem_we
   );

endinterface

// File: rtl/mem_frame_loader.sv
// mem_frame_loader: parses framed write bursts (SYNC, addr, len, data[, chk])
// from a byte stream and writes the data bytes into the register memory.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : stream input + memory write port (mem_frame_loader_if.slave)
//   busy    : state != IDLE
//   done    : one-cycle pulse at frame end
//   err_oob : sticky, a data byte targeted addr >= MEM_DEPTH
//   err_chk : sticky, checksum mismatch (constant 0 unless the macro is set)
// Build option: define MEM_FRAME_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte covering addr, len and all data bytes.
module mem_frame_loader
   import mem_frame_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   mem_frame_loader_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic              err_oob,
   output logic              err_chk
);

`ifdef MEM_FRAME_LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   // State reached once the last data byte (or a zero length) is consumed.
   localparam state_t END_ST = CHK_EN ? S_CHK : S_DONE;

   state_t     state_q, state_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] sum_q, sum_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       we_q, we_d;
   logic       oob_q, oob_d;
   logic       chk_q, chk_d;
   logic       acc;

   assign bus.in_ready = (state_q != S_DONE);
   assign acc          = bus.in_valid && bus.in_ready;
   assign bus.mem_addr = addr_q;
   assign bus.mem_data = data_q;
   assign bus.mem_we   = we_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign err_oob      = oob_q;
   assign err_chk      = chk_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      oob_d   = oob_q;
      chk_d   = chk_q;
      unique case (state_q)
         S_IDLE: if (acc && bus.in_data == SYNC_BYTE) begin
            state_d = S_ADDR;
            oob_d   = 1'b0;
            chk_d   = 1'b0;
         end
         S_ADDR: if (acc) begin
            ptr_d   = bus.in_data;
            sum_d   = bus.in_data;
            state_d = S_LEN;
         end
         S_LEN: if (acc) begin
            cnt_d   = bus.in_data;
            sum_d   = sum_q ^ bus.in_data;
            state_d = (bus.in_data == 8'd0) ? END_ST : S_DATA;
         end
         S_DATA: if (acc) begin
            // Out-of-range bytes are consumed without a write; ptr keeps
            // counting so a wrap past 255 lands back in range.
            we_d    = (ptr_q < DEPTH_B);
            addr_d  = (ptr_q < DEPTH_B) ? ptr_q : addr_q;
            data_d  = (ptr_q < DEPTH_B) ? bus.in_data : data_q;
            oob_d   = oob_q | (ptr_q >= DEPTH_B);
            ptr_d   = ptr_q + 8'd1;
            cnt_d   = cnt_q - 8'd1;
            sum_d   = sum_q ^ bus.in_data;
            state_d = (cnt_q == 8'd1) ? END_ST : S_DATA;
         end
         S_CHK: if (acc) begin
            chk_d   = chk_q | (bus.in_data != sum_q);
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         oob_q   <= 1'b0;
         chk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         oob_q   <= oob_d;
         chk_q   <= chk_d;
      end
   end

endmodule

// File: tb/tb_mem_frame_loader.sv
// tb_mem_frame_loader: directed frames with a write scoreboard for mem_frame_loader.
module tb_mem_frame_loader;
   import mem_frame_loader_pkg::*;

`ifdef MEM_FRAME_LOADER_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic busy, done, err_oob, err_chk;
   int   total = 0;
   int   bad = 0;
   wr_t  sb[$];

   mem_frame_loader_if ifc ();

   mem_frame_loader dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (ifc.slave),
      .busy    (busy),
      .done    (done),
      .err_oob (err_oob),
      .err_chk (err_chk)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t w;
      if (ifc.mem_we === 1'b1) begin
         chk("we_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            w = sb.pop_front();
            chk("sb_addr", 32'(ifc.mem_addr), 32'(w.a));
            chk("sb_data", 32'(ifc.mem_data), 32'(w.d));
         end
      end
      if (done === 1'b1) chk("rdy_in_done", 32'(ifc.in_ready), 0);
   end

   // mode 1: expect the write visible right after acceptance; mode 2: expect none.
   task automatic send(input logic [7:0] b, input int gap, input int mode, input logic [7:0] wa);
      logic rdy;
      rdy = 1'b0;
      ifc.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      ifc.in_data  = b;
      ifc.in_valid = 1'b1;
      for (int k = 0; k < 16 && !rdy; k++) begin
         @(negedge clk);
         rdy = ifc.in_ready;
         @(posedge clk);
         #1;
      end
      ifc.in_valid = 1'b0;
      chk("accept", 32'(rdy), 1);
      if (mode == 1) begin
         chk("we_lat", 32'(ifc.mem_we), 1);
         chk("we_addr", 32'(ifc.mem_addr), 32'(wa));
         chk("we_data", 32'(ifc.mem_data), 32'(b));
      end
      if (mode == 2) chk("oob_no_we", 32'(ifc.mem_we), 0);
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] d[$], input int maxgap,
                        input bit bad_sum, input bit exp_oob);
      logic [7:0] p, s;
      p = a;
      s = a ^ 8'(d.size());
      send(SYNC_BYTE, int'($urandom_range(0, maxgap)), 0, 0);
      chk("busy_sync", 32'(busy), 1);
      chk("oob_clr", 32'(err_oob), 0);
      chk("chk_clr", 32'(err_chk), 0);
      send(a, int'($urandom_range(0, maxgap)), 0, 0);
      send(8'(d.size()), int'($urandom_range(0, maxgap)), 0, 0);
      foreach (d[i]) begin
         if (p < 8'(MEM_DEPTH)) begin
            sb.push_back({p, d[i]});
            send(d[i], int'($urandom_range(0, maxgap)), 1, p);
         end else begin
            send(d[i], int'($urandom_range(0, maxgap)), 2, p);
         end
         s ^= d[i];
         p++;
      end
      if (CHK_ON) send(bad_sum ? ~s : s, int'($urandom_range(0, maxgap)), 0, 0);
      chk("done_pulse", 32'(done), 1);
      chk("rdy_low", 32'(ifc.in_ready), 0);
      chk("busy_done", 32'(busy), 1);
      chk("err_oob", 32'(err_oob), 32'(exp_oob));
      chk("err_chk", 32'(err_chk), 32'(CHK_ON && bad_sum));
      @(posedge clk);
      #1;
      chk("done_once", 32'(done), 0);
      chk("busy_idle", 32'(busy), 0);
      chk("rdy_idle", 32'(ifc.in_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] q[$];
      ifc.in_data  = 8'h00;
      ifc.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ifc.in_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_we", 32'(ifc.mem_we), 0);
      chk("rst_addr", 32'(ifc.mem_addr), 0);
      chk("rst_data", 32'(ifc.mem_data), 0);
      chk("rst_oob", 32'(err_oob), 0);
      chk("rst_chk", 32'(err_chk), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      q = '{8'h11, 8'h22, 8'h33};
      frame(8'h03, q, 0, 1'b0, 1'b0);

      send(8'h00, 0, 0, 0);
      chk("junk_busy0", 32'(busy), 0);
      send(8'hFF, 1, 0, 0);
      chk("junk_busy1", 32'(busy), 0);
      send(8'h5A, 0, 0, 0);
      chk("junk_busy2", 32'(busy), 0);

      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      frame(8'h40, q, 3, 1'b0, 1'b0);

      q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      frame(8'h64, q, 0, 1'b0, 1'b1);

      q.delete();
      frame(8'h10, q, 1, 1'b0, 1'b0);

      q = '{8'h71, 8'h72, 8'h73};
      frame(8'hFE, q, 0, 1'b0, 1'b1);

      q = '{8'h5C, 8'hC5};
      frame(8'h50, q, 0, 1'b1, 1'b0);

      q = '{8'h9E};
      frame(8'h00, q, 2, 1'b0, 1'b0);

      send(SYNC_BYTE, 0, 0, 0);
      send(8'h20, 0, 0, 0);
      send(8'h05, 0, 0, 0);
      sb.push_back({8'h20, 8'hE1});
      send(8'hE1, 0, 1, 8'h20);
      sb.push_back({8'h21, 8'hE2});
      send(8'hE2, 0, 1, 8'h21);
      ifc.in_data  = 8'hE3;
      ifc.in_valid = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_we", 32'(ifc.mem_we), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready", 32'(ifc.in_ready), 1);
      chk("arst_done", 32'(done), 0);
      chk("arst_addr", 32'(ifc.mem_addr), 0);
      chk("arst_data", 32'(ifc.mem_data), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_busy", 32'(busy), 0);

      q = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
      frame(8'h30, q, 1, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
